// File: rtl/arm_regfile.sv
// rtl/arm_regfile.sv - ARM architectural register file R0-R14 with R15 mapped to PC+8
module arm_regfile #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       regSrc,
    input  logic             regWrite,
    input  logic [19:0]      instr,
    input  logic [WIDTH-1:0] wd3,
    input  logic [WIDTH-1:0] pcPlus8,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [3:0]       ra1,
    output logic [3:0]       ra2,
    input  logic [3:0]       dbgAddr,
    output logic [WIDTH-1:0] dbgData
);

    localparam logic [3:0] PC_ADDR = 4'd15;

    logic [WIDTH-1:0] regs [15];
    logic [3:0]       rn;
    logic [3:0]       rd;
    logic [3:0]       rm;
    logic [3:0]       wa3;
    logic             unused_instr_bits;

    assign rn  = instr[19:16];
    assign rd  = instr[15:12];
    assign rm  = instr[3:0];
    assign wa3 = rd;
    assign unused_instr_bits = ^instr[11:4];

    assign ra1 = regSrc[0] ? PC_ADDR : rn;
    assign ra2 = regSrc[1] ? rd : rm;

    // R15 is never stored, so writes aimed at it simply fall away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (regWrite && (wa3 != PC_ADDR)) begin
            regs[wa3] <= wd3;
        end
    end

    // Reads are unbypassed so wd3 can never loop back combinationally into rd1/rd2.
    always_comb begin
        rd1     = (ra1 == PC_ADDR) ? pcPlus8 : regs[ra1];
        rd2     = (ra2 == PC_ADDR) ? pcPlus8 : regs[ra2];
        dbgData = (dbgAddr == PC_ADDR) ? pcPlus8 : regs[dbgAddr];
    end

endmodule

// File: tb/tb_arm_regfile.sv
// tb/tb_arm_regfile.sv - directed and randomized checks of arm_regfile against an array model
module tb_arm_regfile;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   regSrc = 2'b00;
    logic         regWrite = 1'b0;
    logic [19:0]  instr = '0;
    logic [W-1:0] wd3 = '0;
    logic [W-1:0] pcPlus8 = '0;
    logic [W-1:0] rd1, rd2, dbgData;
    logic [3:0]   ra1, ra2;
    logic [3:0]   dbgAddr = '0;

    logic [W-1:0] mdl [16];
    int tests = 0;
    int fails = 0;

    arm_regfile #(.WIDTH(W), .RESET_VALUE(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .regSrc(regSrc), .regWrite(regWrite),
        .instr(instr), .wd3(wd3), .pcPlus8(pcPlus8), .rd1(rd1), .rd2(rd2),
        .ra1(ra1), .ra2(ra2), .dbgAddr(dbgAddr), .dbgData(dbgData)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_rd(input logic [3:0] a);
        return (a == 4'd15) ? pcPlus8 : mdl[a];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fields(input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm);
        instr = {rn, rd, 8'h00, rm};
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    endtask

    // Edge with model update; returns 1 time unit after the rising edge.
    task automatic clock_edge();
        @(posedge clk);
        if (!reset && regWrite === 1'b1 && instr[15:12] != 4'd15) mdl[instr[15:12]] = wd3;
        #1;
    endtask

    task automatic check_ports(input string tag);
        logic [3:0] e1, e2;
        e1 = regSrc[0] ? 4'd15 : instr[19:16];
        e2 = regSrc[1] ? instr[15:12] : instr[3:0];
        check({tag, "_ra1"}, {28'h0, ra1}, {28'h0, e1});
        check({tag, "_ra2"}, {28'h0, ra2}, {28'h0, e2});
        check({tag, "_rd1"}, rd1, ref_rd(e1));
        check({tag, "_rd2"}, rd2, ref_rd(e2));
        check({tag, "_dbg"}, dbgData, ref_rd(dbgAddr));
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [W-1:0] v);
        regWrite = 1'b1;
        fields(4'd0, a, 4'd0);
        wd3 = v;
        clock_edge();
        regWrite = 1'b0;
    endtask

    initial begin
        model_clear();
        #12 reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            dbgAddr = 4'(i);
            #1 check("reset_init", dbgData, 32'h0);
        end

        // Fill with random data, then reset asynchronously mid-cycle.
        for (int i = 0; i < 15; i++) write_reg(4'(i), $urandom | 32'h1);
        #2 reset = 1'b1;
        model_clear();
        pcPlus8 = 32'h108;
        regSrc = 2'b00;
        fields(4'd3, 4'd0, 4'd7);
        #1;
        check("async_rst_rd1", rd1, 32'h0);
        check("async_rst_rd2", rd2, 32'h0);
        regSrc = 2'b01;
        #1;
        check("rst_r15_rd1", rd1, 32'h108);
        check("rst_r15_ra1", {28'h0, ra1}, 32'd15);
        #1 reset = 1'b0;

        // Basic write with no bypass during the write cycle.
        clock_edge();
        regSrc = 2'b00;
        regWrite = 1'b1;
        fields(4'd5, 4'd5, 4'd5);
        wd3 = 32'hDEADBEEF;
        #1 check("no_bypass_rd1", rd1, 32'h0);
        clock_edge();
        regWrite = 1'b0;
        #1;
        check("wr5_rd1", rd1, 32'hDEADBEEF);
        check("wr5_rd2", rd2, 32'hDEADBEEF);

        // R15 write dropped.
        regWrite = 1'b1;
        fields(4'd0, 4'd15, 4'd0);
        wd3 = 32'h12345678;
        clock_edge();
        regWrite = 1'b0;
        dbgAddr = 4'd15;
        #1 check("r15_dbg", dbgData, 32'h108);
        for (int i = 0; i < 15; i++) begin
            dbgAddr = 4'(i);
            #1 check("r15_nochange", dbgData, (i == 5) ? 32'hDEADBEEF : 32'h0);
        end

        // Store addressing.
        write_reg(4'd2, 32'hA5A5A5A5);
        regSrc = 2'b10;
        fields(4'd0, 4'd2, 4'd9);
        #1;
        check("store_ra2", {28'h0, ra2}, 32'd2);
        check("store_rd2", rd2, 32'hA5A5A5A5);
        regSrc = 2'b00;
        #1 check("load_ra2", {28'h0, ra2}, 32'd9);

        // Write all, then a disabled write.
        for (int i = 0; i < 15; i++) write_reg(4'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 15; i++) begin
            dbgAddr = 4'(i);
            #1 check("wr_all", dbgData, 32'h100 + 32'(i));
        end
        regWrite = 1'b0;
        fields(4'd6, 4'd6, 4'd6);
        wd3 = 32'hFFFFFFFF;
        repeat (3) clock_edge();
        check("disabled_r6", rd1, 32'h106);

        // Reset between edges, then a write edge while reset is held.
        #2 reset = 1'b1;
        model_clear();
        #1;
        for (int i = 0; i < 15; i++) begin
            dbgAddr = 4'(i);
            #0 check("rst_all", dbgData, 32'h0);
        end
        regWrite = 1'b1;
        fields(4'd4, 4'd4, 4'd4);
        wd3 = 32'h0000_0BAD;
        clock_edge();
        regWrite = 1'b0;
        check("rst_pri_r4", rd1, 32'h0);
        #2 reset = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            clock_edge();
            regSrc   = 2'($urandom);
            regWrite = 1'($urandom);
            instr    = 20'($urandom);
            wd3      = $urandom;
            pcPlus8  = $urandom;
            dbgAddr  = 4'($urandom);
            #1 check_ports("rand");
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                model_clear();
                #1 check_ports("rand_rst");
                reset = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arm_regfile.md
Name: arm_regfile

Overview:
- Architectural register file for the single-cycle ARM core; sits directly downstream of the controller.
- Consumes the controller's regSrc and regWrite plus the instruction register-field bits.
- Forms the read and write addresses internally and holds R0–R14.
- Supplies operands rd1/rd2 to the ALU/memory datapath and accepts the result writeback.
- R15 is not stored; reads of R15 return PC+8.

Parameters:
- WIDTH, 32, data width of every register and data port.
- RESET_VALUE, 32'h0000_0000, value loaded into R0–R14 on reset.

Ports:
- clk  input  1  core clock; all writes on rising edge.
- reset  input  1  asynchronous, active-high; clears R0–R14 to RESET_VALUE.
- regSrc  input  2  from controller. [0]=1 forces read port 1 address to 15. [1]=1 selects Rd as read port 2 address (stores).
- regWrite  input  1  from controller (already condition-gated); write enable.
- instr  input  20  instr[19:0]: Rn=[19:16], Rd=[15:12], Rm=[3:0]; bits [11:4] ignored.
- wd3  input  WIDTH  writeback result (ALU or memory).
- pcPlus8  input  WIDTH  PC+8, returned for any read of R15.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.
- ra1  output  4  resolved port-1 address (observability).
- ra2  output  4  resolved port-2 address (observability).
- dbgAddr  input  4  debug read address.
- dbgData  output  WIDTH  debug read data; same R15 rule as rd1/rd2.

Behaviour:
- Address formation (combinational):
  - ra1 = regSrc[0] ? 4'd15 : Rn.
  - ra2 = regSrc[1] ? Rd : Rm.
  - Write address wa3 = Rd always.
- Reads:
  - rd1, rd2 and dbgData are purely combinational from the array, with no clock latency.
  - An address of 15 returns pcPlus8. Any other address returns the array entry.
- Writes:
  - On rising clk with regWrite=1 and wa3!=15, R[wa3] <= wd3.
  - Visible on the read ports from the cycle after the edge.
  - No write-through bypass: a same-cycle read of wa3 returns the old value. This prevents an rd→ALU→wd3 combinational loop.
- R15 writes:
  - regWrite=1 with wa3=15 is silently dropped; the array is unchanged.
  - PC update belongs to the fetch stage via PCSrc.
- Simultaneous accesses:
  - Both read ports may address the same register; both return the same data.
  - The debug port is independent and never perturbs state.
- Reset:
  - Asynchronous assertion immediately forces R0–R14 to RESET_VALUE, with no wait for a clock edge.
  - Reset has priority over a coincident write edge.
  - The outputs reflect the reset contents combinationally: rd of R0–R14 = RESET_VALUE, and reads of R15 still return pcPlus8.
  - Deassertion is taken synchronously by the clock domain; the first write can land on the first rising edge with reset low.
- Unknowns:
  - X on regWrite must not corrupt the array beyond the addressed register.
  - X on instr only affects the outputs.

Test Plan:
- Reset then read: assert reset mid-simulation with no clock edge. Drive pcPlus8=0x108, regSrc=00, instr Rn=3, Rm=7 → rd1=rd2=0x0 immediately. Read of R15 via regSrc[0]=1 gives rd1=0x108, ra1=15.
- Basic write/read: regWrite=1, Rd=5, wd3=0xDEADBEEF, one edge. Then Rn=5, Rm=5 → rd1=rd2=0xDEADBEEF. During the write cycle itself, rd1 still shows the old value 0x0.
- R15 write ignored: regWrite=1, Rd=15, wd3=0x12345678, edge → dbgData for addr 15 = pcPlus8. Registers R0–R14 are unchanged: check all 15 via dbgAddr.
- Store addressing: regSrc=10, Rd=2 (holding 0xA5A5A5A5), Rm=9 → ra2=2, rd2=0xA5A5A5A5. With regSrc=00 → ra2=9.
- Write all then reset: write R0..R14 with 0x100+i over 15 edges and verify each. Assert reset between edges → all read 0x0 at once. Next edge with reset high and regWrite=1 leaves R4=0x0.
- Disabled write: regWrite=0, Rd=6, wd3=0xFFFFFFFF, 3 edges → R6 retains its prior value 0x106.
